led_sequencer: RTL and testbench

Parametrised LED pattern engine driving the board LED bank from the single system clock. A built-in prescaler advances a WIDTH-bit pattern once every `period` cycles. The pattern moves in one of four modes: rotate left, rotate right, bounce, or blink. Software-facing controls allow run/pause, single-step and pattern load, so the block can serve as a heartbeat display or a debug status indicator.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_prescaler.sv | 38 +++
 rtl/led_sequencer.sv | 98 +++++++++
 tb/tb_led_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pkg                                                                    |
// | Shared mode, direction and reset-pattern constants for the LED sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package led_pkg;

  localparam logic [1:0] LED_ROT_L  = 2'd0;
  localparam logic [1:0] LED_ROT_R  = 2'd1;
  localparam logic [1:0] LED_BOUNCE = 2'd2;
  localparam logic [1:0] LED_BLINK  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Wide enough for any practical LED bank; truncated to WIDTH at use
  localparam logic [63:0] LED_RST_PATTERN = 64'd1;

endpackage
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_prescaler                                                              |
// | Enable-gated cycle divider producing one expire pulse every max(period,1). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_prescaler #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  input  logic             clear,
  output logic             expire
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_last_cnt;
  logic             w_at_last;

  // Using >= rather than == lets a stale count after a period decrease wrap at once
  assign w_last_cnt = (period == '0) ? '0 : period - DIV_W'(1);
  assign w_at_last  = (r_cnt >= w_last_cnt);
  assign expire     = en & w_at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_sequencer                                                              |
// | LED pattern engine: rotate, bounce or blink on prescaler expiry or step.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_sequencer
  import led_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  input  logic             step,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_pattern,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             tick
);

  logic [WIDTH-1:0] r_led;
  logic             r_dir;
  logic             r_tick;
  logic [WIDTH-1:0] w_led_nxt;
  logic             w_dir_nxt;
  logic             w_expire;
  logic             w_advance;

  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .period (period),
    .clear  (step | load_valid),
    .expire (w_expire)
  );

  assign w_advance = w_expire | step;

  always_comb begin
    w_led_nxt = r_led;
    w_dir_nxt = r_dir;
    case (mode)
      LED_ROT_L: w_led_nxt = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
      LED_ROT_R: w_led_nxt = {r_led[0], r_led[WIDTH-1:1]};
      LED_BOUNCE: begin
        // Reverse at the end bit instead of shifting it out
        if (r_dir == DIR_LEFT) begin
          if (r_led[WIDTH-1]) begin
            w_dir_nxt = DIR_RIGHT;
            w_led_nxt = r_led >> 1;
          end else begin
            w_led_nxt = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_dir_nxt = DIR_LEFT;
            w_led_nxt = r_led << 1;
          end else begin
            w_led_nxt = r_led >> 1;
          end
        end
      end
      default: w_led_nxt = ~r_led;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led  <= WIDTH'(LED_RST_PATTERN);
      r_dir  <= DIR_LEFT;
      r_tick <= 1'b0;
    end else if (load_valid) begin
      r_led  <= load_pattern;
      r_dir  <= DIR_LEFT;
      r_tick <= 1'b0;
    end else if (w_advance) begin
      r_led  <= w_led_nxt;
      r_dir  <= w_dir_nxt;
      r_tick <= 1'b1;
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign led  = r_led;
  assign dir  = r_dir;
  assign tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_sequencer                                                           |
// | Directed self-checking bench for led_sequencer with WIDTH=8, DIV_W=8.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_led_sequencer;

  localparam int WIDTH = 8;
  localparam int DIV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic             step;
  logic             load_valid;
  logic [WIDTH-1:0] load_pattern;
  logic [WIDTH-1:0] led;
  logic             dir;
  logic             tick;

  int n_checks = 0;
  int n_errors = 0;

  led_sequencer #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .period       (period),
    .step         (step),
    .load_valid   (load_valid),
    .load_pattern (load_pattern),
    .led          (led),
    .dir          (dir),
    .tick         (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] pat);
    load_pattern = pat;
    load_valid   = 1'b1;
    edges(1);
    load_valid   = 1'b0;
  endtask

  // Bounce from 0x01, one advance per cycle
  logic [7:0] bounce_led [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic       bounce_dir [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    mode         = 2'd0;
    period       = 8'd4;
    step         = 1'b0;
    load_valid   = 1'b0;
    load_pattern = '0;
    #22 rst_n = 1'b1;
    edges(1);
    chk("rst_led", led, 8'h01);
    chk("rst_dir", dir, 1'b0);
    chk("rst_tick", tick, 1'b0);

    // ROT_L free run, period 4
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] prev_v;
      logic [7:0] exp_v;
      prev_v = (8'h01 << i);
      exp_v  = (i == 7) ? 8'h01 : (8'h01 << (i + 1));
      edges(3);
      chk("rotl_hold", led, prev_v);
      chk("rotl_hold_tick", tick, 1'b0);
      edges(1);
      chk("rotl_led", led, exp_v);
      chk("rotl_tick", tick, 1'b1);
    end

    // BOUNCE from 0x01, period 1
    en = 1'b0;
    do_load(8'h01);
    chk("load_tick", tick, 1'b0);
    mode   = 2'd2;
    period = 8'd1;
    en     = 1'b1;
    for (int i = 0; i < 15; i++) begin
      edges(1);
      chk("bounce_led", led, bounce_led[i]);
      chk("bounce_dir", dir, bounce_dir[i]);
      chk("bounce_tick", tick, 1'b1);
    end

    // Async reset mid-run with led=0x20, dir=1, tick=1
    en = 1'b0;
    do_load(8'h80);
    en = 1'b1;
    edges(2);
    chk("pre_rst_led", led, 8'h20);
    chk("pre_rst_dir", dir, 1'b1);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 8'h01);
    chk("async_rst_dir", dir, 1'b0);
    chk("async_rst_tick", tick, 1'b0);
    #3 rst_n = 1'b1;
    edges(1);

    // BLINK via step, including back-to-back steps and all-zero pattern
    mode = 2'd3;
    do_load(8'hA5);
    chk("blink_load", led, 8'hA5);
    step = 1'b1;
    edges(1);
    chk("blink_1", led, 8'h5A);
    chk("blink_1_tick", tick, 1'b1);
    edges(1);
    step = 1'b0;
    chk("blink_2", led, 8'hA5);
    chk("blink_2_tick", tick, 1'b1);
    do_load(8'h00);
    step = 1'b1;
    edges(1);
    step = 1'b0;
    chk("blink_zero", led, 8'hFF);

    // period 0 acts as 1
    mode = 2'd0;
    do_load(8'h01);
    period = 8'd0;
    en     = 1'b1;
    edges(1);
    chk("p0_a", led, 8'h02);
    edges(1);
    chk("p0_b", led, 8'h04);
    edges(1);
    chk("p0_c", led, 8'h08);

    // Lower period from 200 to 3 while count is 10
    en     = 1'b0;
    period = 8'd200;
    do_load(8'h01);
    en = 1'b1;
    edges(10);
    chk("p200_hold", led, 8'h01);
    period = 8'd3;
    edges(1);
    chk("p3_stale_wrap", led, 8'h02);
    chk("p3_stale_tick", tick, 1'b1);
    edges(2);
    chk("p3_hold", led, 8'h02);
    edges(1);
    chk("p3_next", led, 8'h04);

    // Pause at count 1, resume: expire after two more enabled cycles
    edges(1);
    en = 1'b0;
    edges(60);
    chk("pause_led", led, 8'h04);
    chk("pause_tick", tick, 1'b0);
    en = 1'b1;
    edges(1);
    chk("resume_hold", led, 8'h04);
    edges(1);
    chk("resume_adv", led, 8'h08);

    // Single step while paused
    en   = 1'b0;
    edges(1);
    step = 1'b1;
    edges(1);
    step = 1'b0;
    chk("step_led", led, 8'h10);
    chk("step_tick", tick, 1'b1);
    edges(1);
    chk("step_once_led", led, 8'h10);
    chk("step_once_tick", tick, 1'b0);

    // Load beats step in the same cycle
    mode         = 2'd2;
    step         = 1'b1;
    load_valid   = 1'b1;
    load_pattern = 8'h3C;
    edges(1);
    step       = 1'b0;
    load_valid = 1'b0;
    chk("prio_led", led, 8'h3C);
    chk("prio_tick", tick, 1'b0);
    chk("prio_dir", dir, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
